bcd_down_timer: RTL and testbench

//   Multi-digit BCD countdown timer; the down-counting complement of the team's decade up-counter.

---
 rtl/bcd_down_timer_if.sv | 25 ++
 rtl/bcd_down_timer.sv | 135 +++++++++++++
 tb/tb_bcd_down_timer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for the BCD countdown timer.
interface bcd_down_timer_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned CW = 4 * DIGITS;

    logic          load;
    logic [CW-1:0] load_value;
    logic          start;
    logic          pause;
    logic [CW-1:0] count;
    logic          running;
    logic          tick;
    logic          done;

    modport master (
        output load, load_value, start, pause,
        input  count, running, tick, done
    );

    modport slave (
        input  load, load_value, start, pause,
        output count, running, tick, done
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer with prescaled tick, pause/resume and a
// one-cycle done pulse on reaching zero.
module bcd_down_timer #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 50
) (
    input  logic              clk,
    input  logic              reset,
    bcd_down_timer_if.slave   bus
);
    localparam int unsigned CW   = 4 * DIGITS;
    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        PAUSED   = 2'd2,
        FINISHED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic          running_q;
    logic [CW-1:0] dec_value;

    // Clamp any non-decimal digit to 9.
    function automatic logic [CW-1:0] sanitise(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Subtract one with decade borrow rippling across all digits.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign dec_value = bcd_dec(count_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            running_q <= (state_d == RUN);
        end
    end

    // Next-state logic; priority load > pause > start.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        if (bus.load) begin
            count_d = sanitise(bus.load_value);
            presc_d = '0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.pause) begin
                        if (count_q != '0) begin
                            state_d = RUN;
                        end else begin
                            state_d = FINISHED;
                            done_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_d = PAUSED;
                    end else if (count_q == '0) begin
                        state_d = FINISHED;
                    end else if (presc_q == LAST) begin
                        presc_d = '0;
                        count_d = dec_value;
                        tick_d  = 1'b1;
                        if (dec_value == '0) begin
                            done_d  = 1'b1;
                            state_d = FINISHED;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSED: begin
                    if (bus.start && !bus.pause) state_d = RUN;
                end
                FINISHED: begin
                    if (bus.start && !bus.pause) done_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.tick    = tick_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer (DIGITS=4, TICK_DIV=4).
module tb_bcd_down_timer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   tick_total = 0;

    bcd_down_timer_if #(.DIGITS(4)) bus ();

    bcd_down_timer #(.DIGITS(4), .TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Expect n decrements from decimal value 'from'; first one after 'gap' cycles.
    task automatic run_ticks(input string tag, input int from, input int n, input int gap);
        int g;
        int cur;
        g = gap;
        for (int k = 1; k <= n; k++) begin
            cur = from - k + 1;
            for (int j = 1; j < g; j++) begin
                step();
                chk({tag, "_hold_tick"}, 32'(bus.tick), 32'd0);
                chk({tag, "_hold_count"}, 32'(bus.count), 32'(to_bcd(cur)));
                chk({tag, "_hold_done"}, 32'(bus.done), 32'd0);
            end
            step();
            if (bus.tick) tick_total++;
            chk({tag, "_tick"}, 32'(bus.tick), 32'd1);
            chk({tag, "_count"}, 32'(bus.count), 32'(to_bcd(cur - 1)));
            chk({tag, "_done"}, 32'(bus.done), (cur - 1 == 0) ? 32'd1 : 32'd0);
            chk({tag, "_running"}, 32'(bus.running), (cur - 1 != 0) ? 32'd1 : 32'd0);
            g = 4;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load       = 1'b1;
        bus.load_value = v;
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.load       = 1'b0;
        bus.load_value = '0;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;

        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rst_count", 32'(bus.count), 32'h0);
            chk("rst_running", 32'(bus.running), 32'd0);
            chk("rst_tick", 32'(bus.tick), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
        end

        // Full countdown from 12.
        do_load(16'h0012);
        chk("ld12_count", 32'(bus.count), 32'h0012);
        chk("ld12_running", 32'(bus.running), 32'd0);
        do_start();
        chk("st12_running", 32'(bus.running), 32'd1);
        tick_total = 0;
        run_ticks("cd12", 12, 12, 4);
        chk("cd12_ticks", 32'(tick_total), 32'd12);
        step();
        chk("cd12_after_done", 32'(bus.done), 32'd0);
        chk("cd12_after_running", 32'(bus.running), 32'd0);
        chk("cd12_after_count", 32'(bus.count), 32'h0);

        // Borrow ripple across all digits.
        do_load(16'h1000);
        do_start();
        run_ticks("ripple", 1000, 1, 4);
        chk("ripple_value", 32'(bus.count), 32'h0999);

        // Pause mid-period and resume with preserved prescaler phase.
        do_load(16'h0005);
        do_start();
        run_ticks("pre_pause", 5, 2, 4);
        step();
        chk("phase1_count", 32'(bus.count), 32'h0003);
        bus.pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("pause_count", 32'(bus.count), 32'h0003);
            chk("pause_tick", 32'(bus.tick), 32'd0);
            chk("pause_running", 32'(bus.running), 32'd0);
        end
        bus.pause = 1'b0;
        do_start();
        chk("resume_running", 32'(bus.running), 32'd1);
        run_ticks("resume", 3, 3, 3);

        // Clamp invalid digits.
        do_load(16'h0A0F);
        chk("clamp_count", 32'(bus.count), 32'h0909);

        // Start at zero finishes immediately; start in FINISHED pulses again.
        do_load(16'h0000);
        do_start();
        chk("zero_done", 32'(bus.done), 32'd1);
        chk("zero_running", 32'(bus.running), 32'd0);
        chk("zero_tick", 32'(bus.tick), 32'd0);
        step();
        chk("zero_done_clear", 32'(bus.done), 32'd0);
        do_start();
        chk("fin_restart_done", 32'(bus.done), 32'd1);
        step();
        chk("fin_restart_clear", 32'(bus.done), 32'd0);

        // Load beats pause and start while running; prescaler restarts from 0.
        do_load(16'h0050);
        do_start();
        step();
        step();
        bus.pause = 1'b1;
        bus.start = 1'b1;
        do_load(16'h0042);
        bus.pause = 1'b0;
        bus.start = 1'b0;
        chk("ldrun_count", 32'(bus.count), 32'h0042);
        chk("ldrun_running", 32'(bus.running), 32'd0);
        chk("ldrun_tick", 32'(bus.tick), 32'd0);
        step();
        chk("ldrun_idle_running", 32'(bus.running), 32'd0);
        chk("ldrun_idle_count", 32'(bus.count), 32'h0042);
        do_start();
        run_ticks("ldrun", 42, 1, 4);

        // Reset mid-count clears everything with no done pulse.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_count", 32'(bus.count), 32'h0);
        chk("midrst_running", 32'(bus.running), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_tick", 32'(bus.tick), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("postrst_done", 32'(bus.done), 32'd0);
            chk("postrst_count", 32'(bus.count), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
